// File: rtl/multi_eq_checker_pkg.sv
// Shared types and helpers for the N-channel lockstep equality checker.
package multi_eq_checker_pkg;

    typedef enum logic [1:0] {
        ST_MATCH,
        ST_RUN,
        ST_ALARM
    } run_st_e;

    // Largest value representable in a w-bit saturating counter.
    function automatic longint unsigned cnt_max(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/eq_lane.sv
// Per-channel comparator: flags any bit difference against channel 0.
module eq_lane #(
    parameter int W = 3
) (
    input  logic [W-1:0] ch0,
    input  logic [W-1:0] ch,
    output logic         diff
);

    assign diff = |(ch ^ ch0);

endmodule

// File: rtl/multi_eq_checker.sv
// Two-stage N-channel equality checker with saturating mismatch count
// and a sticky alarm on a run of consecutive mismatching results.
module multi_eq_checker
    import multi_eq_checker_pkg::*;
#(
    parameter int N        = 3,
    parameter int W        = 3,
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N*W-1:0]   in_data,
    input  logic             clr,
    output logic             out_valid,
    output logic             all_eq,
    output logic [N-1:0]     diff_mask,
    output logic [CNT_W-1:0] mism_cnt,
    output logic             alarm
);

    localparam int               STAGES  = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] TH      = CNT_W'(ALARM_TH);

    logic [STAGES:1]     vld_pipe;
    logic [N-1:0][W-1:0] s1_data;
    logic [N-1:0]        diff_c;
    logic                s1_vld;
    logic                mism;

    run_st_e          state_q, state_n;
    logic [CNT_W-1:0] run_q, run_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             alarm_q, alarm_n;

    assign s1_vld    = vld_pipe[1];
    assign out_valid = vld_pipe[STAGES];

    // s1_data only loads on valid, so X on an idle bus never reaches the compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            if (in_valid)
                s1_data <= in_data;
        end
    end

    assign diff_c[0] = 1'b0;

    for (genvar k = 1; k < N; k++) begin : g_lane
        eq_lane #(.W(W)) u_lane (
            .ch0  (s1_data[0]),
            .ch   (s1_data[k]),
            .diff (diff_c[k])
        );
    end

    assign mism = s1_vld & (|diff_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_eq    <= 1'b0;
            diff_mask <= '0;
        end else if (s1_vld) begin
            all_eq    <= ~|diff_c;
            diff_mask <= diff_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MATCH;
            run_q   <= '0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_n;
            run_q   <= run_n;
            cnt_q   <= cnt_n;
            alarm_q <= alarm_n;
        end
    end

    // Statistics only move on result cycles; clr wins over a coincident result.
    always_comb begin
        state_n = state_q;
        run_n   = run_q;
        cnt_n   = cnt_q;
        alarm_n = alarm_q;
        if (clr) begin
            state_n = ST_MATCH;
            run_n   = '0;
            cnt_n   = '0;
            alarm_n = 1'b0;
        end else if (s1_vld) begin
            if (mism && cnt_q != CNT_MAX)
                cnt_n = cnt_q + 1'b1;
            case (state_q)
                ST_MATCH: begin
                    if (mism) begin
                        run_n = CNT_W'(1);
                        if (TH == CNT_W'(1)) begin
                            state_n = ST_ALARM;
                            alarm_n = 1'b1;
                        end else begin
                            state_n = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (mism) begin
                        run_n = run_q + 1'b1;
                        if (run_q + 1'b1 == TH) begin
                            state_n = ST_ALARM;
                            alarm_n = 1'b1;
                        end
                    end else begin
                        run_n   = '0;
                        state_n = ST_MATCH;
                    end
                end
                ST_ALARM: begin
                    alarm_n = 1'b1;
                    if (mism && run_q != CNT_MAX)
                        run_n = run_q + 1'b1;
                end
                default: state_n = ST_MATCH;
            endcase
        end
    end

    assign mism_cnt = cnt_q;
    assign alarm    = alarm_q;

endmodule

// File: tb/tb_multi_eq_checker.sv
// Randomised bench for multi_eq_checker against a cycle-level behavioural model.
module tb_multi_eq_checker;

    localparam int N     = 3;
    localparam int W     = 3;
    localparam int CNT_W = 8;
    localparam int TH    = 4;
    localparam int NW    = N * W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [NW-1:0]    in_data;
    logic             clr;
    logic             out_valid;
    logic             all_eq;
    logic [N-1:0]     diff_mask;
    logic [CNT_W-1:0] mism_cnt;
    logic             alarm;

    multi_eq_checker #(.N(N), .W(W), .CNT_W(CNT_W), .ALARM_TH(TH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr       (clr),
        .out_valid (out_valid),
        .all_eq    (all_eq),
        .diff_mask (diff_mask),
        .mism_cnt  (mism_cnt),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: the last accepted sample plus the expected visible outputs.
    bit            pv;
    logic [NW-1:0] pd;
    bit            e_ov, e_eq, e_alarm;
    logic [N-1:0]  e_mask;
    int            e_cnt, run;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_mask(input logic [NW-1:0] d);
        logic [N-1:0] m;
        m = '0;
        for (int k = 1; k < N; k++)
            m[k] = (d[k*W +: W] != d[W-1:0]);
        return m;
    endfunction

    function automatic logic [NW-1:0] mk(input bit bad);
        logic [W-1:0]  c0;
        logic [NW-1:0] d;
        int            k, b;
        c0 = W'($urandom);
        d  = {N{c0}};
        if (bad) begin
            k = $urandom_range(N-1, 1);
            b = $urandom_range(W-1, 0);
            d[k*W + b] = ~d[k*W + b];
            if ($urandom_range(0, 1) == 1)
                d[W-1:0] = ~d[W-1:0];
        end
        return d;
    endfunction

    task automatic model_reset();
        pv = 0; pd = '0;
        e_ov = 0; e_eq = 0; e_mask = '0;
        e_cnt = 0; run = 0; e_alarm = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".out_valid"}, out_valid, e_ov);
        chk({tag, ".all_eq"},    all_eq,    e_eq);
        chk({tag, ".diff_mask"}, diff_mask, e_mask);
        chk({tag, ".mism_cnt"},  mism_cnt,  e_cnt);
        chk({tag, ".alarm"},     alarm,     e_alarm);
    endtask

    // Drive one cycle, then advance the model by the result that edge produces.
    task automatic step(input bit v, input logic [NW-1:0] d, input bit c);
        in_valid = v;
        in_data  = v ? d : NW'($urandom);
        clr      = c;
        @(posedge clk);
        #1;
        if (pv) begin
            e_mask = ref_mask(pd);
            e_eq   = (e_mask == '0);
        end
        e_ov = pv;
        if (c) begin
            e_cnt = 0; run = 0; e_alarm = 0;
        end else if (pv) begin
            if (e_mask != '0) begin
                if (e_cnt < CMAX) e_cnt++;
                run++;
                if (run >= TH) e_alarm = 1;
            end else if (!e_alarm) begin
                run = 0;
            end
        end
        pv = v;
        pd = d;
        check_outs("cyc");
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; in_data = '0;
        model_reset();
        #12;
        check_outs("reset");
        rst_n = 1'b1;
        step(0, '0, 0);

        // All channels equal.
        step(1, {3'd5, 3'd5, 3'd5}, 0);
        step(0, '0, 0);
        chk("eq.ov",   out_valid, 1);
        chk("eq.all",  all_eq,    1);
        chk("eq.mask", diff_mask, 0);
        step(0, '0, 0);

        // Single bit difference on channel 2.
        step(1, 9'b100_101_101, 0);
        step(0, '0, 0);
        chk("sb.mask", diff_mask, 3'b100);
        chk("sb.cnt",  mism_cnt,  1);

        // 3 mismatches, 1 match, 4 mismatches, then matches.
        step(0, '0, 1);
        for (int i = 0; i < 3; i++) step(1, mk(1), 0);
        step(1, mk(0), 0);
        for (int i = 0; i < 4; i++) step(1, mk(1), 0);
        for (int i = 0; i < 4; i++) step(1, mk(0), 0);
        step(0, '0, 0);
        chk("al.cnt",   mism_cnt, 7);
        chk("al.alarm", alarm,    1);

        // clr coinciding with a mismatch result.
        step(1, mk(1), 0);
        step(0, '0, 1);
        chk("clr.cnt",   mism_cnt, 0);
        chk("clr.alarm", alarm,    0);
        step(0, '0, 0);

        // Back-to-back, then a mismatch run spanning input gaps.
        for (int i = 0; i < 8; i++) step(1, mk($urandom_range(0, 1) == 1), 0);
        step(1, mk(0), 0);
        step(0, '0, 1);
        for (int i = 0; i < 12; i++) step(i % 2 == 0, mk(1), 0);
        step(0, '0, 0);
        chk("gap.alarm", alarm, 1);

        // Saturation of the mismatch counter.
        step(0, '0, 1);
        for (int i = 0; i < CMAX + 40; i++) step(1, mk(1), 0);
        step(0, '0, 0);
        step(0, '0, 0);
        chk("sat.cnt", mism_cnt, CMAX);

        // Reset in the middle of traffic.
        for (int i = 0; i < 3; i++) step(1, mk($urandom_range(0, 1) == 1), 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("mrst");
        #3;
        rst_n = 1'b1;
        step(1, mk(1), 0);
        step(1, mk(0), 0);
        step(0, '0, 0);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, mk($urandom_range(0, 2) == 0),
                 $urandom_range(0, 40) == 0);
        step(0, '0, 0);
        step(0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
